// File: rtl/tt_pattern_tx.sv
// rtl/tt_pattern_tx.sv - edge-list stimulus driver for the shortest-path engine
// Buffers host edges, streams one query + edge task, and returns the engine's cost.
module tt_pattern_tx #(
  parameter int MAX_EDGES = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       edge_clr,
  input  logic       load_valid,
  input  logic [3:0] load_src,
  input  logic [3:0] load_dst,
  output logic       load_ready,
  input  logic       start,
  input  logic [3:0] query_src,
  input  logic [3:0] query_dst,
  output logic       busy,
  output logic       in_valid,
  output logic [3:0] source,
  output logic [3:0] destination,
  input  logic       out_valid,
  input  logic [3:0] cost,
  output logic       result_valid,
  output logic [3:0] result_cost,
  output logic       result_timeout
);

  localparam int AW = (MAX_EDGES > 1) ? $clog2(MAX_EDGES) : 1;
  localparam int CW = $clog2(MAX_EDGES) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_EDGES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_QUERY, S_EDGE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_ptr;
  logic [TW-1:0]   r_tmo;
  logic            r_in_valid;
  logic [3:0]      r_source;
  logic [3:0]      r_destination;
  logic            r_result_valid;
  logic [3:0]      r_result_cost;
  logic            r_result_timeout;
  logic [7:0]      r_buf [MAX_EDGES];

  logic            w_load_ready;
  logic            w_wr;
  logic [7:0]      w_rd;

  assign w_load_ready = (r_state == S_IDLE) && (r_cnt < MAX_C);
  // A start or clear in the same cycle wins over the offered edge.
  assign w_wr         = w_load_ready && load_valid && !edge_clr && !start;
  assign w_rd         = r_buf[r_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf[r_cnt[AW-1:0]] <= {load_src, load_dst};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_ptr            <= '0;
      r_tmo            <= '0;
      r_in_valid       <= 1'b0;
      r_source         <= '0;
      r_destination    <= '0;
      r_result_valid   <= 1'b0;
      r_result_cost    <= '0;
      r_result_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (edge_clr) begin
            r_cnt <= '0;
          end else if (w_wr) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (start) begin
            r_ptr         <= '0;
            r_in_valid    <= 1'b1;
            r_source      <= query_src;
            r_destination <= query_dst;
            r_state       <= S_QUERY;
          end
        end
        S_QUERY: begin
          if (r_cnt != '0) begin
            r_source      <= w_rd[7:4];
            r_destination <= w_rd[3:0];
            r_ptr         <= CW'(1);
            r_state       <= S_EDGE;
          end else begin
            r_in_valid    <= 1'b0;
            r_source      <= '0;
            r_destination <= '0;
            r_tmo         <= '0;
            r_state       <= S_WAIT;
          end
        end
        S_EDGE: begin
          if (r_ptr == r_cnt) begin
            r_in_valid    <= 1'b0;
            r_source      <= '0;
            r_destination <= '0;
            r_tmo         <= '0;
            r_state       <= S_WAIT;
          end else begin
            r_source      <= w_rd[7:4];
            r_destination <= w_rd[3:0];
            r_ptr         <= r_ptr + CW'(1);
          end
        end
        S_WAIT: begin
          if (out_valid) begin
            r_result_cost    <= cost;
            r_result_timeout <= 1'b0;
            r_result_valid   <= 1'b1;
            r_state          <= S_DONE;
          end else if (r_tmo == TMO_LAST) begin
            r_result_cost    <= '0;
            r_result_timeout <= 1'b1;
            r_result_valid   <= 1'b1;
            r_state          <= S_DONE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_DONE: begin
          r_result_valid <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign load_ready     = w_load_ready;
  assign busy           = (r_state != S_IDLE);
  assign in_valid       = r_in_valid;
  assign source         = r_source;
  assign destination    = r_destination;
  assign result_valid   = r_result_valid;
  assign result_cost    = r_result_cost;
  assign result_timeout = r_result_timeout;

endmodule

// File: tb/tb_tt_pattern_tx.sv
// tb/tb_tt_pattern_tx.sv - directed scoreboard bench for tt_pattern_tx
module tb_tt_pattern_tx;

  localparam int MAX_EDGES = 32;
  localparam int TIMEOUT   = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       edge_clr = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_src = '0;
  logic [3:0] load_dst = '0;
  logic       load_ready;
  logic       start = 1'b0;
  logic [3:0] query_src = '0;
  logic [3:0] query_dst = '0;
  logic       busy;
  logic       in_valid;
  logic [3:0] source;
  logic [3:0] destination;
  logic       out_valid = 1'b0;
  logic [3:0] cost = '0;
  logic       result_valid;
  logic [3:0] result_cost;
  logic       result_timeout;

  int checks = 0;
  int errors = 0;
  logic [7:0] model[$];
  logic [7:0] sb[$];

  tt_pattern_tx #(.MAX_EDGES(MAX_EDGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .edge_clr(edge_clr),
    .load_valid(load_valid), .load_src(load_src), .load_dst(load_dst),
    .load_ready(load_ready), .start(start), .query_src(query_src),
    .query_dst(query_dst), .busy(busy), .in_valid(in_valid),
    .source(source), .destination(destination), .out_valid(out_valid),
    .cost(cost), .result_valid(result_valid), .result_cost(result_cost),
    .result_timeout(result_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_edge(input logic [3:0] s, input logic [3:0] d);
    logic exp_rdy;
    exp_rdy = (model.size() < MAX_EDGES);
    load_valid = 1'b1; load_src = s; load_dst = d;
    chk("load_ready", 32'(load_ready), 32'(exp_rdy));
    if (exp_rdy) model.push_back({s, d});
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // resp_at: WAIT cycle index (0 = first WAIT cycle) to pulse out_valid, -1 = never
  task automatic run_task(input logic [3:0] qs, input logic [3:0] qd, input int resp_at,
                          input logic [3:0] rcost, input bit poke);
    int nb, n_exp, w, exp_lat;
    logic [7:0] e;
    logic quiet_bad;
    sb.push_back({qs, qd});
    foreach (model[i]) sb.push_back(model[i]);
    n_exp = sb.size();
    exp_lat = (resp_at >= 0 && resp_at < TIMEOUT) ? resp_at + 1 : TIMEOUT;
    query_src = qs; query_dst = qd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("iv_rise", 32'(in_valid), 1);
    nb = 0;
    while (in_valid === 1'b1 && nb < MAX_EDGES + 8) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("beat", {24'h0, source, destination}, {24'h0, e});
      end
      if (poke && nb == 1) begin
        start = 1'b1; query_src = 4'hF; query_dst = 4'hE;
      end
      nb++;
      @(negedge clk);
      start = 1'b0;
    end
    chk("beat_count", nb, n_exp);
    sb.delete();
    quiet_bad = 1'b0;
    w = 0;
    while (result_valid !== 1'b1 && w < TIMEOUT + 20) begin
      if (in_valid !== 1'b0 || source !== 4'h0 || destination !== 4'h0) quiet_bad = 1'b1;
      if (w == resp_at) begin out_valid = 1'b1; cost = rcost; end
      if (poke && w == 1) begin
        load_valid = 1'b1; load_src = 4'h9; load_dst = 4'h9;
        chk("load_ready_busy", 32'(load_ready), 0);
      end
      @(negedge clk);
      out_valid = 1'b0; cost = '0; load_valid = 1'b0;
      w++;
    end
    chk("wait_quiet", 32'(quiet_bad), 0);
    chk("rv_latency", w, exp_lat);
    chk("res_cost", 32'(result_cost), (exp_lat == TIMEOUT && resp_at != TIMEOUT - 1) ? 0 : 32'(rcost));
    chk("res_timeout", 32'(result_timeout), (resp_at < 0 || resp_at >= TIMEOUT) ? 1 : 0);
    chk("busy_done", 32'(busy), 1);
    @(negedge clk);
    chk("rv_pulse", 32'(result_valid), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_valid", 32'(in_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load_ready", 32'(load_ready), 1);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_result_cost", 32'(result_cost), 0);
    chk("rst_result_timeout", 32'(result_timeout), 0);

    load_edge(4'd0, 4'd1);
    load_edge(4'd1, 4'd2);
    load_edge(4'd2, 4'd3);
    run_task(4'd0, 4'd3, 2, 4'd3, 1'b0);
    run_task(4'd3, 4'd0, 5, 4'd7, 1'b1);

    out_valid = 1'b1; cost = 4'hF;
    @(negedge clk);
    out_valid = 1'b0; cost = '0;
    chk("stray_rv", 32'(result_valid), 0);
    chk("stray_cost", 32'(result_cost), 7);

    run_task(4'd0, 4'd3, -1, 4'd0, 1'b0);
    run_task(4'd0, 4'd3, TIMEOUT - 1, 4'd9, 1'b0);

    edge_clr = 1'b1; load_valid = 1'b1; load_src = 4'h4; load_dst = 4'h4;
    @(negedge clk);
    edge_clr = 1'b0; load_valid = 1'b0;
    model.delete();
    chk("clr_load_ready", 32'(load_ready), 1);
    run_task(4'd5, 4'd5, 0, 4'd0, 1'b0);

    for (int i = 0; i < MAX_EDGES + 1; i++)
      load_edge(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    chk("full_model", model.size(), MAX_EDGES);
    run_task(4'd1, 4'd2, 3, 4'd4, 1'b0);

    query_src = 4'd2; query_dst = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_edge_iv", 32'(in_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_iv", 32'(in_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_load_ready", 32'(load_ready), 1);
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_task(4'd5, 4'd5, 0, 4'd6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_pattern_tx.md
Name: tt_pattern_tx

Overview:
- Transmit-side driver for the shortest-path engine's edge-stream interface (in_valid/source/destination in, out_valid/cost back).
- Buffers a host-loaded edge list, then on start drives one task: a query beat followed by the edge beats.
- Waits for the engine's single-cycle result pulse, with a timeout, and returns the cost to the host.
- Used as the on-chip stimulus front end for the engine and as its reusable system-side adapter.

Parameters:
- MAX_EDGES, 32: edge buffer depth, in edges.
- TIMEOUT, 255: cycles allowed in WAIT for out_valid before the task is abandoned.

Ports:
- clk  in  1  single system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- edge_clr  in  1  clears the edge buffer; ignored while busy
- load_valid  in  1  host offers one edge
- load_src  in  4  edge endpoint A
- load_dst  in  4  edge endpoint B
- load_ready  out  1  high when idle and edge count < MAX_EDGES
- start  in  1  launch a task; sampled only in IDLE
- query_src  in  4  path source node
- query_dst  in  4  path destination node
- busy  out  1  high in every state except IDLE
- in_valid  out  1  to engine
- source  out  4  to engine
- destination  out  4  to engine
- out_valid  in  1  from engine; one-cycle result pulse
- cost  in  4  from engine; 0 means unreachable
- result_valid  out  1  one-cycle pulse, task finished
- result_cost  out  4  captured cost; 0 on timeout
- result_timeout  out  1  qualified by result_valid; 1 means no out_valid within TIMEOUT

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; edge count and read pointer go to 0.
  - All outputs go to 0 except load_ready, which goes to 1. Buffer contents are don't-care.
  - Reset mid-task drops in_valid immediately, with no further beats.
- Loading, IDLE only:
  - load_valid && load_ready writes {load_src, load_dst} at index count, then count increments.
  - count is $clog2(MAX_EDGES)+1 bits wide and saturates at MAX_EDGES.
  - When count == MAX_EDGES, load_ready is low and the write is dropped.
  - edge_clr has priority over a same-cycle load: count becomes 0 and no write happens.
  - Buffer contents and count persist across tasks, so the same graph can be reused for many queries.
- State machine: IDLE -> QUERY -> EDGE -> WAIT -> DONE -> IDLE.
  - IDLE: start=1 latches query_src and query_dst, sets read pointer to 0, and moves to QUERY. A simultaneous load_valid is dropped.
  - QUERY, one cycle: drives in_valid=1, source=query_src, destination=query_dst.
    - Moves to EDGE if count > 0, otherwise to WAIT.
  - EDGE: drives in_valid=1 with buffer[ptr] for exactly count cycles, with ptr incrementing each cycle.
    - After the last beat, moves to WAIT.
    - Beats are back-to-back; there is no gap between the query beat and the first edge beat.
  - WAIT: drives in_valid=0, source=0, destination=0. A timeout counter starts at 0 and increments every cycle.
    - out_valid=1 captures cost into result_cost, clears result_timeout, and moves to DONE.
    - If the counter reaches TIMEOUT with no out_valid: result_cost=0, result_timeout=1, move to DONE.
    - If out_valid and the timeout arrive in the same cycle, out_valid wins.
  - DONE, one cycle: result_valid=1, then moves to IDLE. result_cost and result_timeout hold until the next DONE.
- Outputs to the engine are registered:
  - in_valid rises on the cycle after start is sampled.
  - The in_valid high run lasts exactly 1+count cycles, with no gap and no extra beat.
- source/destination are 0 whenever in_valid is 0.
- out_valid outside WAIT is a protocol violation: it is ignored and leaves result_* unchanged.
- start while busy is ignored. load_valid while busy is ignored (load_ready is low).
- Self-loop or duplicate edges are forwarded unchanged; the engine tolerates them.
- After DONE, in_valid stays low for at least one cycle before the next QUERY, as the engine requires.

Test Plan:
- Reset then idle: after rst_n release, in_valid=0, busy=0, load_ready=1, result_valid=0. Assert rst_n low during EDGE -> in_valid=0 in the same cycle and count=0.
- Chain graph: load 0-1, 1-2, 2-3; start with query 0->3 -> in_valid high 4 cycles with beats (0,3),(0,1),(1,2),(2,3). Engine model returns cost=3 -> result_valid pulse, result_cost=3, result_timeout=0.
- Zero edges: count=0, start with query 5->5 -> exactly one in_valid beat (5,5), then WAIT.
- Full buffer: load 33 edges with MAX_EDGES=32 -> load_ready low after the 32nd, 33rd dropped, task emits 33 beats.
- Timeout: engine never asserts out_valid -> result_valid exactly TIMEOUT cycles after WAIT entry (TIMEOUT=255), result_cost=0, result_timeout=1. Repeat with out_valid on that same cycle -> result_timeout=0.
- Reuse and guards: assert start during EDGE and load_valid during WAIT -> both ignored. A second start after DONE with query 3->0 re-sends the same 3 edges in order.
